// File: rtl/vc_mem_arbiter_2port.sv
// Two-port memory arbiter: round-robin grant, in-order ID FIFO for response routing.
// Define VC_MEM_ARB_FIXED_PRIO_EN to make port 0 always win ties (no last-grant state).
module vc_mem_arbiter_2port #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_max_inflight = 4,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits
                                   + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + 2
                                   + c_len_nbits + p_data_nbits
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [c_req_nbits-1:0]  req0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [c_resp_nbits-1:0] resp0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [c_req_nbits-1:0]  req1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [c_resp_nbits-1:0] resp1_msg,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [c_req_nbits-1:0]  memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [c_resp_nbits-1:0] memresp_msg
);

    localparam int c_ptr_nbits = $clog2(p_max_inflight);
    localparam logic [c_ptr_nbits-1:0] c_ptr_one = c_ptr_nbits'(1);
    localparam logic [c_ptr_nbits:0]   c_cnt_one = (c_ptr_nbits + 1)'(1);
    localparam logic [c_ptr_nbits:0]   c_full    = (c_ptr_nbits + 1)'(p_max_inflight);

    logic                   r_ids [p_max_inflight];
    logic [c_ptr_nbits-1:0] r_wr_ptr;
    logic [c_ptr_nbits-1:0] r_rd_ptr;
    logic [c_ptr_nbits:0]   r_count;

    logic w_gnt0;
    logic w_gnt1;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;

`ifdef VC_MEM_ARB_FIXED_PRIO_EN
    assign w_gnt0 = req0_val;
`else
    logic r_last;

    // r_last holds the most recent grant; the other port wins a tie.
    assign w_gnt0 = req0_val && (!req1_val || r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_push) begin
            r_last <= w_gnt1;
        end
    end
`endif

    assign w_gnt1  = req1_val && !w_gnt0;
    assign w_full  = (r_count == c_full);
    assign w_empty = (r_count == '0);
    assign w_head  = r_ids[r_rd_ptr];

    assign memreq_val = (req0_val || req1_val) && !w_full && !reset;
    assign memreq_msg = w_gnt1 ? req1_msg : req0_msg;
    assign req0_rdy   = w_gnt0 && memreq_rdy && !w_full && !reset;
    assign req1_rdy   = w_gnt1 && memreq_rdy && !w_full && !reset;

    assign resp0_val   = memresp_val && !w_empty && !w_head && !reset;
    assign resp1_val   = memresp_val && !w_empty && w_head && !reset;
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign memresp_rdy = (w_head ? resp1_rdy : resp0_rdy) && !w_empty && !reset;

    assign w_push = memreq_val && memreq_rdy;
    assign w_pop  = memresp_val && memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ids[r_wr_ptr] <= w_gnt1;
        end
    end

`ifndef SYNTHESIS
    a_resp_without_req: assert property (
        @(posedge clk) disable iff (reset) !(memresp_val && w_empty)
    );
`endif

endmodule

// File: tb/tb_vc_mem_arbiter_2port.sv
// Scoreboard bench for vc_mem_arbiter_2port: directed scenarios plus random
// traffic against an in-order reference model and a behavioural memory.
module tb_vc_mem_arbiter_2port;

    localparam int RQ   = 77;
    localparam int RS   = 47;
    localparam int MAXF = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rv [2];
    logic [RQ-1:0] rm [2];

    logic req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RQ-1:0] req0_msg, req1_msg;
    logic resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [RS-1:0] resp0_msg, resp1_msg;
    logic memreq_val, memreq_rdy;
    logic [RQ-1:0] memreq_msg;
    logic memresp_val, memresp_rdy;
    logic [RS-1:0] memresp_msg;

    assign req0_val = rv[0];
    assign req1_val = rv[1];
    assign req0_msg = rm[0];
    assign req1_msg = rm[1];

    vc_mem_arbiter_2port dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference: outstanding port IDs in issue order and per-port expected responses.
    int ids[$];
    int last_grant = 1;
    int grant_log[$];
    logic [RS-1:0] exp0[$];
    logic [RS-1:0] exp1[$];
    logic [31:0] ref_mem [logic [31:0]];

    logic [RS-1:0] dev_q[$];
    logic [31:0] dev_mem [logic [31:0]];

    int fire_cnt [2];
    bit fired [2];
    bit mresp_fired = 1'b0;
    logic [31:0] last_data [2];
    logic [2:0] last_type [2];
    int seq = 0;

    bit auto_req [2];
    bit auto_resp = 1'b0;
    bit auto_rdy = 1'b0;
    bit auto_mrdy = 1'b0;
    bit fixed_addr = 1'b0;
    int req_rate = 100;
    int resp_rate = 100;
    int rdy_rate = 100;
    int mrdy_rate = 100;

    task automatic check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic checkm(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [RQ-1:0] mk_req(int p, bit wr, logic [31:0] addr,
                                             logic [31:0] data);
        logic [7:0] op;
        op = {p[0], seq[6:0]};
        seq++;
        return {wr ? 3'd1 : 3'd0, op, addr, 2'd0, data};
    endfunction

    function automatic logic [RS-1:0] resp_of(logic [RQ-1:0] q, logic [31:0] rd);
        return {q[76:74], q[73:66], 2'b00, q[33:32], (q[76:74] == 3'd0) ? rd : 32'h0};
    endfunction

    always @(negedge clk) begin : mon
        bit any, full, ne;
        int win, h;
        logic [RQ-1:0] q;
        logic [RS-1:0] e;
        logic [31:0] a, rd;
        if (reset) begin
            check1("rst_memreq_val", memreq_val, 1'b0);
            check1("rst_req0_rdy", req0_rdy, 1'b0);
            check1("rst_req1_rdy", req1_rdy, 1'b0);
            check1("rst_resp0_val", resp0_val, 1'b0);
            check1("rst_resp1_val", resp1_val, 1'b0);
            check1("rst_memresp_rdy", memresp_rdy, 1'b0);
            ids.delete();
            exp0.delete();
            exp1.delete();
            dev_q.delete();
            last_grant = 1;
        end else begin
            any  = req0_val || req1_val;
            full = ids.size() == MAXF;
`ifdef VC_MEM_ARB_FIXED_PRIO_EN
            win = req0_val ? 0 : 1;
`else
            win = (req0_val && req1_val) ? 1 - last_grant : (req0_val ? 0 : 1);
`endif
            check1("memreq_val", memreq_val, any && !full);
            check1("req0_rdy", req0_rdy, any && !full && win == 0 && memreq_rdy);
            check1("req1_rdy", req1_rdy, any && !full && win == 1 && memreq_rdy);
            if (any) checkm("memreq_msg", 128'(memreq_msg), 128'(win == 1 ? req1_msg : req0_msg));

            ne = ids.size() > 0;
            h  = ne ? ids[0] : 0;
            check1("resp0_val", resp0_val, memresp_val && ne && h == 0);
            check1("resp1_val", resp1_val, memresp_val && ne && h == 1);
            check1("memresp_rdy", memresp_rdy, ne && (h == 1 ? resp1_rdy : resp0_rdy));
            checkm("resp0_msg_pass", 128'(resp0_msg), 128'(memresp_msg));
            checkm("resp1_msg_pass", 128'(resp1_msg), 128'(memresp_msg));

            if (memresp_val && memresp_rdy) begin
                if ((h == 0 && exp0.size() == 0) || (h == 1 && exp1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: port %0d acknowledged a response, required none", h);
                end else begin
                    e = (h == 0) ? exp0.pop_front() : exp1.pop_front();
                    checkm("resp_sb", 128'(h == 0 ? resp0_msg : resp1_msg), 128'(e));
                end
                last_data[h] = (h == 0) ? resp0_msg[31:0] : resp1_msg[31:0];
                last_type[h] = (h == 0) ? resp0_msg[46:44] : resp1_msg[46:44];
                if (ne) void'(ids.pop_front());
                if (dev_q.size() > 0) void'(dev_q.pop_front());
                mresp_fired = 1'b1;
            end

            if (memreq_val && memreq_rdy) begin
                q  = (win == 1) ? req1_msg : req0_msg;
                a  = q[65:34];
                rd = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                if (q[76:74] == 3'd1) ref_mem[a] = q[31:0];
                if (win == 0) exp0.push_back(resp_of(q, rd));
                else exp1.push_back(resp_of(q, rd));
                ids.push_back(win);
                last_grant = win;
                grant_log.push_back(win);
                a  = memreq_msg[65:34];
                rd = dev_mem.exists(a) ? dev_mem[a] : 32'h0;
                if (memreq_msg[76:74] == 3'd1) dev_mem[a] = memreq_msg[31:0];
                dev_q.push_back(resp_of(memreq_msg, rd));
            end
            if (req0_val && req0_rdy) begin
                fired[0] = 1'b1;
                fire_cnt[0]++;
            end
            if (req1_val && req1_rdy) begin
                fired[1] = 1'b1;
                fire_cnt[1]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (auto_req[p] && (!rv[p] || fired[p])) begin
                rv[p] = $urandom_range(99) < req_rate;
                rm[p] = mk_req(p, fixed_addr ? 1'b0 : $urandom_range(1) == 1,
                               fixed_addr ? 32'(p * 4) : 32'($urandom_range(7) * 4),
                               $urandom);
            end else if (!auto_req[p] && fired[p]) begin
                rv[p] = 1'b0;
            end
            fired[p] = 1'b0;
        end
        if (reset) begin
            memresp_val = 1'b0;
        end else if (auto_resp) begin
            if (!memresp_val || mresp_fired) begin
                memresp_val = dev_q.size() > 0 && $urandom_range(99) < resp_rate;
                memresp_msg = dev_q.size() > 0 ? dev_q[0] : '0;
            end
        end else if (mresp_fired) begin
            memresp_val = 1'b0;
        end
        mresp_fired = 1'b0;
        if (auto_rdy) begin
            resp0_rdy = $urandom_range(99) < rdy_rate;
            resp1_rdy = $urandom_range(99) < rdy_rate;
        end
        if (auto_mrdy) memreq_rdy = $urandom_range(99) < mrdy_rate;
    endtask

    task automatic drain();
        int n;
        tick();
        auto_req[0] = 1'b0;
        auto_req[1] = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        auto_resp = 1'b1;
        resp_rate = 100;
        auto_rdy = 1'b0;
        auto_mrdy = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        n = 0;
        while ((ids.size() > 0 || dev_q.size() > 0) && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (ids.size() > 0 || dev_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d still outstanding, required 0", ids.size());
        end
    endtask

    task automatic wait_fires(int p, int k);
        int start, n;
        start = fire_cnt[p];
        n = 0;
        while (fire_cnt[p] < start + k && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (fire_cnt[p] < start + k) begin
            n_fail++;
            $display("FAIL wait_fire: port %0d got %0d fires, required %0d", p, fire_cnt[p] - start, k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rm[0] = '0;
        rm[1] = '0;
        auto_req[0] = 1'b0;
        auto_req[1] = 1'b0;
        fired[0] = 1'b0;
        fired[1] = 1'b0;
        fire_cnt[0] = 0;
        fire_cnt[1] = 0;
        last_data[0] = '0;
        last_data[1] = '0;
        last_type[0] = '0;
        last_type[1] = '0;
        memreq_rdy = 1'b0;
        memresp_val = 1'b0;
        memresp_msg = '0;
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset.
        memreq_rdy = 1'b1;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check1("idle_memreq_val", memreq_val, 1'b0);
        check1("idle_req0_rdy", req0_rdy, 1'b0);
        check1("idle_req1_rdy", req1_rdy, 1'b0);
        check1("idle_resp_val", resp0_val || resp1_val, 1'b0);

        // Continuous contention, fixed read addresses.
        tick();
        grant_log.delete();
        auto_resp = 1'b1;
        resp_rate = 100;
        fixed_addr = 1'b1;
        req_rate = 100;
        auto_req[0] = 1'b1;
        auto_req[1] = 1'b1;
        repeat (8) tick();
        drain();
        checkm("rr_log_len", 128'(grant_log.size() >= 4), 128'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) begin
`ifdef VC_MEM_ARB_FIXED_PRIO_EN
                checkm("grant_seq", 128'(grant_log[i]), 128'(0));
`else
                checkm("grant_seq", 128'(grant_log[i]), 128'(i % 2));
`endif
            end
        end

        // Fill the ID FIFO with no responses; the fifth request must stall.
        auto_resp = 1'b0;
        memresp_val = 1'b0;
        memreq_rdy = 1'b1;
        start = fire_cnt[0];
        auto_req[0] = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check1("full_memreq_val", memreq_val, 1'b0);
        checkm("full_fires", 128'(fire_cnt[0] - start), 128'(4));
        tick();
        memresp_val = 1'b1;
        memresp_msg = dev_q[0];
        @(negedge clk);
        check1("full_pop_no_issue", memreq_val, 1'b0);
        check1("full_pop_rdy", memresp_rdy, 1'b1);
        tick();
        @(negedge clk);
        check1("fifth_issues", memreq_val, 1'b1);
        drain();

        // Port-1 write then port-0 read of the same address.
        rm[1] = mk_req(1, 1'b1, 32'h10, 32'hdeadbeef);
        rv[1] = 1'b1;
        wait_fires(1, 1);
        rm[0] = mk_req(0, 1'b0, 32'h10, 32'h0);
        rv[0] = 1'b1;
        wait_fires(0, 1);
        drain();
        checkm("rd_after_wr_data", 128'(last_data[0]), 128'(32'hdeadbeef));
        checkm("wr_resp_type", 128'(last_type[1]), 128'(3'd1));
        checkm("wr_resp_data", 128'(last_data[1]), 128'(32'h0));

        // Head-of-line: port-0 response blocked while port 1 is ready.
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b1;
        rm[0] = mk_req(0, 1'b0, 32'h4, 32'h0);
        rv[0] = 1'b1;
        wait_fires(0, 1);
        @(negedge clk);
        check1("hol_memresp_rdy", memresp_rdy, 1'b0);
        check1("hol_resp1_val", resp1_val, 1'b0);
        check1("hol_resp0_val", resp0_val, 1'b1);
        tick();
        @(negedge clk);
        check1("hol_memresp_rdy2", memresp_rdy, 1'b0);
        tick();
        resp0_rdy = 1'b1;
        @(negedge clk);
        check1("hol_release", memresp_rdy, 1'b1);
        drain();

        // Reset with three outstanding, then a tie.
        auto_resp = 1'b0;
        memresp_val = 1'b0;
        fixed_addr = 1'b1;
        auto_req[0] = 1'b1;
        wait_fires(0, 3);
        auto_req[0] = 1'b0;
        rv[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rm[0] = mk_req(0, 1'b0, 32'h0, 32'h0);
        rm[1] = mk_req(1, 1'b0, 32'h4, 32'h0);
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        @(negedge clk);
        check1("post_rst_memreq_val", memreq_val, 1'b1);
        check1("post_rst_gnt0", req0_rdy, 1'b1);
        check1("post_rst_gnt1", req1_rdy, 1'b0);
        drain();

        // Random traffic with random back-pressure everywhere.
        fixed_addr = 1'b0;
        req_rate = 60;
        auto_req[0] = 1'b1;
        auto_req[1] = 1'b1;
        auto_resp = 1'b1;
        resp_rate = 50;
        auto_rdy = 1'b1;
        rdy_rate = 70;
        auto_mrdy = 1'b1;
        mrdy_rate = 70;
        repeat (3000) tick();
        memreq_rdy = 1'b1;
        drain();
        n_checks++;
        if (exp0.size() > 0 || exp1.size() > 0) begin
            n_fail++;
            $display("FAIL leftover: %0d/%0d responses undelivered, required 0", exp0.size(), exp1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
